bsg_fifo_1r1w_rolly_mc: RTL and testbench

//  Multi-channel rollback FIFO: channels_p independent rolly queues sharing one
//  1r1w memory, statically partitioned into els_p slots per channel.
//  - Write side: speculative enqueue with commit or drop.
//  - Read side: speculative dequeue with rollback or ack.

---
 rtl/bsg_fifo_1r1w_rolly_mc_if.sv | 39 +++
 rtl/bsg_fifo_1r1w_rolly_mc.sv | 129 ++++++++++++
 tb/tb_bsg_fifo_1r1w_rolly_mc.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_fifo_1r1w_rolly_mc_if.sv
// Request/status bundle of the multi-channel rolly FIFO; the master drives the
// requests and the slave (the FIFO) returns readiness, head data and counts.
interface bsg_fifo_1r1w_rolly_mc_if #(
  parameter int width_p    = 8,
  parameter int els_p      = 4,
  parameter int channels_p = 2
);
  localparam int cid_w = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [cid_w-1:0]            w_chan_i;
  logic [width_p-1:0]          data_i;
  logic                        v_i;
  logic [channels_p-1:0]       ready_o;
  logic                        clr_v_i;
  logic                        commit_not_drop_v_i;
  logic                        commit_not_drop_i;
  logic [cid_w-1:0]            r_chan_i;
  logic [width_p-1:0]          data_o;
  logic [channels_p-1:0]       v_o;
  logic                        yumi_i;
  logic                        deq_v_i;
  logic                        rollback_v_i;
  logic                        ack_v_i;
  logic [channels_p*cnt_w-1:0] count_o;
  logic [channels_p*cnt_w-1:0] free_o;

  modport master (
    output w_chan_i, data_i, v_i, clr_v_i, commit_not_drop_v_i, commit_not_drop_i,
           r_chan_i, yumi_i, deq_v_i, rollback_v_i, ack_v_i,
    input  ready_o, data_o, v_o, count_o, free_o
  );

  modport slave (
    input  w_chan_i, data_i, v_i, clr_v_i, commit_not_drop_v_i, commit_not_drop_i,
           r_chan_i, yumi_i, deq_v_i, rollback_v_i, ack_v_i,
    output ready_o, data_o, v_o, count_o, free_o
  );
endinterface

// File: rtl/bsg_fifo_1r1w_rolly_mc.sv
// Multi-channel rollback FIFO over one shared 1r1w memory; head data is combinational,
// enqueued data readable one cycle after commit; per-channel ready_o drops when full or clearing.
module bsg_fifo_1r1w_rolly_mc #(
  parameter int width_p            = 8,
  parameter int els_p              = 4,
  parameter int channels_p         = 2,
  parameter bit ready_then_valid_p = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_fifo_1r1w_rolly_mc_if.slave io
);
  localparam int ptr_w  = $clog2(els_p);
  localparam int pw     = ptr_w + 1;
  localparam int cid_w  = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam int cnt_w  = $clog2(els_p + 1);
  localparam int addr_w = cid_w + ptr_w;

  logic [pw-1:0] r_rptr  [channels_p];
  logic [pw-1:0] r_rcptr [channels_p];
  logic [pw-1:0] r_wptr  [channels_p];
  logic [pw-1:0] r_wcptr [channels_p];
  logic [pw-1:0] w_rptr_n  [channels_p];
  logic [pw-1:0] w_rcptr_n [channels_p];
  logic [pw-1:0] w_wptr_n  [channels_p];
  logic [pw-1:0] w_wcptr_n [channels_p];

  logic [width_p-1:0] r_mem [channels_p*els_p];

  logic [channels_p-1:0] w_empty, w_full, w_ready;
  logic [channels_p-1:0] w_wsel, w_rsel, w_rd, w_dq, w_enq_c;
  logic                  w_enq;
  logic [addr_w-1:0]     w_waddr, w_raddr;

  assign w_enq   = io.v_i & (ready_then_valid_p ? 1'b1 : w_ready[io.w_chan_i]);
  assign w_waddr = {io.w_chan_i, r_wptr[io.w_chan_i][ptr_w-1:0]};
  assign w_raddr = {io.r_chan_i, r_rptr[io.r_chan_i][ptr_w-1:0]};
  assign io.data_o  = r_mem[w_raddr];
  assign io.ready_o = w_ready;

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    w_ready = '0;
    w_wsel  = '0;
    w_rsel  = '0;
    w_rd    = '0;
    w_dq    = '0;
    w_enq_c = '0;
    io.v_o     = '0;
    io.count_o = '0;
    io.free_o  = '0;
    for (int c = 0; c < channels_p; c++) begin
      w_wsel[c]  = (io.w_chan_i == cid_w'(c));
      w_rsel[c]  = (io.r_chan_i == cid_w'(c));
      w_empty[c] = (r_rptr[c] == r_wcptr[c]);
      // Full compares against the read checkpoint: slots behind it may still be replayed.
      w_full[c]  = (r_rcptr[c][ptr_w-1:0] == r_wptr[c][ptr_w-1:0]) &&
                   (r_rcptr[c][ptr_w] != r_wptr[c][ptr_w]);
      w_ready[c] = ~w_full[c] & ~(io.clr_v_i & w_wsel[c]);
      io.v_o[c]  = ~w_empty[c] & ~(io.rollback_v_i & w_rsel[c]);
      w_rd[c]    = io.yumi_i & w_rsel[c];
      w_dq[c]    = io.deq_v_i & ~w_empty[c] & w_rsel[c];
      w_enq_c[c] = w_enq & w_wsel[c];
      io.count_o[c*cnt_w +: cnt_w] = cnt_w'(r_wcptr[c] - r_rptr[c]);
      io.free_o[c*cnt_w +: cnt_w]  = cnt_w'(pw'(els_p) - (r_wptr[c] - r_rcptr[c]));
    end
  end

  always_comb begin
    for (int c = 0; c < channels_p; c++) begin
      w_rptr_n[c]  = r_rptr[c] + pw'(w_rd[c]);
      w_rcptr_n[c] = r_rcptr[c] + pw'(w_dq[c]);
      w_wptr_n[c]  = r_wptr[c] + pw'(w_enq_c[c]);
      w_wcptr_n[c] = r_wcptr[c];
      if (w_rsel[c] & io.rollback_v_i)
        w_rptr_n[c] = r_rcptr[c] + pw'(w_dq[c]);
      if (w_rsel[c] & io.ack_v_i)
        w_rcptr_n[c] = r_rptr[c];
      // Clear keeps only data already handed to the reader (including this cycle's yumi).
      if (w_wsel[c] & io.clr_v_i) begin
        w_wptr_n[c]  = r_rptr[c] + pw'(w_rd[c]);
        w_wcptr_n[c] = r_rptr[c] + pw'(w_rd[c]);
      end else if (w_wsel[c] & io.commit_not_drop_v_i) begin
        if (io.commit_not_drop_i)
          w_wcptr_n[c] = r_wptr[c] + pw'(w_enq_c[c]);
        else
          w_wptr_n[c] = r_wcptr[c];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < channels_p; c++) begin
        r_rptr[c]  <= '0;
        r_rcptr[c] <= '0;
        r_wptr[c]  <= '0;
        r_wcptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < channels_p; c++) begin
        r_rptr[c]  <= w_rptr_n[c];
        r_rcptr[c] <= w_rcptr_n[c];
        r_wptr[c]  <= w_wptr_n[c];
        r_wcptr[c] <= w_wcptr_n[c];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq)
      r_mem[w_waddr] <= io.data_i;
  end

  // Deq may accompany rollback (the checkpoint advances before the read pointer rewinds).
  a_rd_ops:   assert property (@(posedge clk_i) disable iff (reset_i)
                $onehot0({io.rollback_v_i, io.ack_v_i}) && !(io.ack_v_i && io.deq_v_i));
  a_deq:      assert property (@(posedge clk_i) disable iff (reset_i)
                !(io.deq_v_i && w_empty[io.r_chan_i]));
  a_yumi:     assert property (@(posedge clk_i) disable iff (reset_i)
                !(io.yumi_i && !io.v_o[io.r_chan_i]));
  a_chan:     assert property (@(posedge clk_i) disable iff (reset_i)
                (int'(io.w_chan_i) < channels_p) && (int'(io.r_chan_i) < channels_p));
  a_clr_cnd:  assert property (@(posedge clk_i) disable iff (reset_i)
                !(io.commit_not_drop_v_i && io.clr_v_i));
  a_rtv:      assert property (@(posedge clk_i) disable iff (reset_i)
                !(ready_then_valid_p && io.v_i && !w_ready[io.w_chan_i]));
endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_mc.sv
// Bench for bsg_fifo_1r1w_rolly_mc: vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_bsg_fifo_1r1w_rolly_mc;
  localparam int W = 8, E = 4, C = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bsg_fifo_1r1w_rolly_mc_if #(.width_p(W), .els_p(E), .channels_p(C)) io ();
  bsg_fifo_1r1w_rolly_mc #(.width_p(W), .els_p(E), .channels_p(C), .ready_then_valid_p(1'b0))
    dut (.clk_i(clk), .reset_i(rst), .io(io));

  typedef struct packed {
    logic       wc;
    logic [7:0] d;
    logic       v, cv, c, clr, rc, y, dq, rb, ak;
  } in_t;

  typedef struct {
    in_t        i;
    logic [1:0] ev, er;
    logic [5:0] cnt, fr;
    logic [7:0] ed;
  } vec_t;

  int tests = 0, fails = 0;

  // Reference model: per channel, the entries from the read checkpoint up to the write
  // pointer, how many of them the reader has consumed, and how many are committed.
  logic [7:0] mq [C][$];
  int nrd [C];
  int ncm [C];

  function automatic in_t mk(logic wc, logic [7:0] d, logic v, logic cv, logic c, logic clr,
                             logic rc, logic y, logic dq, logic rb, logic ak);
    in_t x;
    x.wc = wc; x.d = d; x.v = v; x.cv = cv; x.c = c; x.clr = clr;
    x.rc = rc; x.y = y; x.dq = dq; x.rb = rb; x.ak = ak;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive(in_t x);
    io.w_chan_i = x.wc; io.data_i = x.d; io.v_i = x.v;
    io.clr_v_i = x.clr; io.commit_not_drop_v_i = x.cv; io.commit_not_drop_i = x.c;
    io.r_chan_i = x.rc; io.yumi_i = x.y; io.deq_v_i = x.dq;
    io.rollback_v_i = x.rb; io.ack_v_i = x.ak;
  endtask

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      mq[c].delete();
      nrd[c] = 0;
      ncm[c] = 0;
    end
  endtask

  task automatic trim(int c, int k);
    while (mq[c].size() > k) void'(mq[c].pop_back());
  endtask

  task automatic model_check(in_t x);
    for (int c = 0; c < C; c++) begin
      chk($sformatf("ready_o[%0d]", c), io.ready_o[c],
          (mq[c].size() < E) && !(x.clr && int'(x.wc) == c));
      chk($sformatf("v_o[%0d]", c), io.v_o[c], (ncm[c] > nrd[c]) && !(x.rb && int'(x.rc) == c));
      chk($sformatf("count_o[%0d]", c), io.count_o[c*3 +: 3], ncm[c] - nrd[c]);
      chk($sformatf("free_o[%0d]", c), io.free_o[c*3 +: 3], E - mq[c].size());
    end
    if (ncm[x.rc] > nrd[x.rc] && !x.rb)
      chk("data_o", io.data_o, mq[x.rc][nrd[x.rc]]);
  endtask

  task automatic model_step(in_t x);
    int w, r, pre_n;
    logic enq, dq;
    w = x.wc;
    r = x.rc;
    enq = x.v && (mq[w].size() < E) && !x.clr;
    dq  = x.dq && (ncm[r] > nrd[r]);
    if (x.ak) begin
      pre_n = nrd[r];
      repeat (pre_n) void'(mq[r].pop_front());
      ncm[r] -= pre_n;
      nrd[r] = x.y ? 1 : 0;
    end else begin
      if (x.y) nrd[r]++;
      if (dq) begin
        void'(mq[r].pop_front());
        ncm[r]--;
        nrd[r]--;
      end
      if (x.rb) nrd[r] = 0;
    end
    if (enq) mq[w].push_back(x.d);
    if (x.clr) begin
      trim(w, nrd[w]);
      ncm[w] = nrd[w];
    end else if (x.cv) begin
      if (x.c) ncm[w] = mq[w].size();
      else trim(w, ncm[w]);
    end
  endtask

  task automatic pre(in_t x);
    drive(x);
    #1;
    model_check(x);
  endtask

  task automatic post(in_t x);
    @(posedge clk);
    model_step(x);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    drive('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vt [12];
  in_t  x;
  int   wi, ri;

  initial begin
    model_reset();
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    pre('0);
    chk("rst ready_o", io.ready_o, 2'b11);
    chk("rst v_o", io.v_o, 2'b00);
    chk("rst count_o", io.count_o, 6'o00);
    chk("rst free_o", io.free_o, 6'o44);
    post('0);

    // Commit/read on ch1, then drop on ch0
    vt[0]  = '{mk(1, 8'hA1, 1, 0, 0, 0, 1, 0, 0, 0, 0), 2'b00, 2'b11, 6'o00, 6'o44, 8'h00};
    vt[1]  = '{mk(1, 8'hA2, 1, 1, 1, 0, 1, 0, 0, 0, 0), 2'b00, 2'b11, 6'o00, 6'o34, 8'h00};
    vt[2]  = '{mk(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0), 2'b10, 2'b11, 6'o20, 6'o24, 8'hA1};
    vt[3]  = '{mk(1, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 0), 2'b10, 2'b11, 6'o20, 6'o24, 8'hA1};
    vt[4]  = '{mk(1, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 0), 2'b10, 2'b11, 6'o10, 6'o24, 8'hA2};
    vt[5]  = '{mk(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0), 2'b00, 2'b11, 6'o00, 6'o24, 8'h00};
    vt[6]  = '{mk(0, 8'h11, 1, 1, 1, 0, 0, 0, 0, 0, 0), 2'b00, 2'b11, 6'o00, 6'o24, 8'h00};
    vt[7]  = '{mk(0, 8'h22, 1, 0, 0, 0, 0, 0, 0, 0, 0), 2'b01, 2'b11, 6'o01, 6'o23, 8'h11};
    vt[8]  = '{mk(0, 8'h33, 1, 0, 0, 0, 0, 0, 0, 0, 0), 2'b01, 2'b11, 6'o01, 6'o22, 8'h11};
    vt[9]  = '{mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0), 2'b01, 2'b11, 6'o01, 6'o21, 8'h11};
    vt[10] = '{mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0), 2'b01, 2'b11, 6'o01, 6'o23, 8'h11};
    vt[11] = '{mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 2'b11, 6'o00, 6'o23, 8'h00};
    foreach (vt[k]) begin
      pre(vt[k].i);
      chk($sformatf("vec%0d v_o", k), io.v_o, vt[k].ev);
      chk($sformatf("vec%0d ready_o", k), io.ready_o, vt[k].er);
      chk($sformatf("vec%0d count_o", k), io.count_o, vt[k].cnt);
      chk($sformatf("vec%0d free_o", k), io.free_o, vt[k].fr);
      if (vt[k].ev[vt[k].i.rc])
        chk($sformatf("vec%0d data_o", k), io.data_o, vt[k].ed);
      post(vt[k].i);
    end

    // Reset asserted between edges while ch0 holds committed data
    for (int k = 0; k < 3; k++) begin
      x = mk(0, 8'(8'h30 + k), 1, k == 2, 1, 0, 0, 0, 0, 0, 0);
      pre(x);
      post(x);
    end
    pre('0);
    chk("pre-reset v_o", io.v_o, 2'b01);
    post('0);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst v_o", io.v_o, 2'b00);
    chk("async rst ready_o", io.ready_o, 2'b11);
    chk("async rst count_o", io.count_o, 6'o00);
    chk("async rst free_o", io.free_o, 6'o44);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full and pointer wrap on ch0
    for (int lap = 0; lap < 2; lap++) begin
      for (int k = 0; k < 4; k++) begin
        x = mk(0, 8'(8'h40 + 16*lap + k), 1, 1, 1, 0, 0, 0, 0, 0, 0);
        pre(x);
        post(x);
      end
      pre('0);
      chk("full ready_o", io.ready_o, 2'b10);
      chk("full free_o", io.free_o, 6'o40);
      post('0);
      for (int k = 0; k < 4; k++) begin
        x = mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        pre(x);
        chk("wrap data_o", io.data_o, 8'(8'h40 + 16*lap + k));
        post(x);
      end
      x = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      pre(x);
      post(x);
    end

    // Rollback with deq on ch1
    do_reset();
    for (int k = 0; k < 3; k++) begin
      x = mk(1, 8'(8'h61 + k), 1, k == 2, 1, 0, 1, 0, 0, 0, 0);
      pre(x);
      post(x);
    end
    x = mk(1, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    pre(x);
    chk("rb head0", io.data_o, 8'h61);
    post(x);
    x = mk(1, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    pre(x);
    chk("rb head1", io.data_o, 8'h62);
    post(x);
    x = mk(1, 8'h00, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    pre(x);
    chk("rb v_o[1]", io.v_o[1], 1'b0);
    post(x);
    x = mk(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    pre(x);
    chk("after rb v_o[1]", io.v_o[1], 1'b1);
    chk("after rb data_o", io.data_o, 8'h63);
    chk("after rb count_o[1]", io.count_o[5:3], 3'd1);
    chk("after rb free_o[1]", io.free_o[5:3], 3'd3);
    post(x);

    // Clear with same-channel yumi, then cross-channel traffic
    do_reset();
    for (int k = 0; k < 3; k++) begin
      x = mk(0, 8'(8'h71 + k), 1, k == 2, 1, 0, 0, 0, 0, 0, 0);
      pre(x);
      post(x);
    end
    x = mk(1, 8'h81, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    pre(x);
    post(x);
    x = mk(0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    pre(x);
    chk("clr ready_o", io.ready_o, 2'b10);
    chk("clr data_o", io.data_o, 8'h71);
    post(x);
    x = mk(1, 8'h82, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    pre(x);
    chk("clr count_o[0]", io.count_o[2:0], 3'd0);
    chk("clr v_o[0]", io.v_o[0], 1'b0);
    chk("clr free_o[0]", io.free_o[2:0], 3'd3);
    chk("clr count_o[1]", io.count_o[5:3], 3'd1);
    post(x);
    x = mk(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    pre(x);
    chk("cross count_o[1]", io.count_o[5:3], 3'd2);
    post(x);

    // Random legal traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      x = '0;
      x.wc = 1'($urandom_range(0, 1));
      x.rc = 1'($urandom_range(0, 1));
      wi = x.wc;
      ri = x.rc;
      x.d = 8'($urandom);
      x.v = 1'($urandom);
      case ($urandom_range(0, 9))
        0:       x.clr = 1'b1;
        1, 2, 3: begin x.cv = 1'b1; x.c = 1'($urandom); end
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0:       x.rb = !(x.clr && wi == ri);
        1:       x.ak = 1'b1;
        default: ;
      endcase
      x.y  = !x.rb && (ncm[ri] > nrd[ri]) && ($urandom_range(0, 2) != 0);
      x.dq = !x.ak && (ncm[ri] > nrd[ri]) && (nrd[ri] > 0 || x.y || x.rb) &&
             ($urandom_range(0, 1) == 1);
      pre(x);
      post(x);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
